aes128_crypto_core: RTL and testbench

//  Iterative AES-128 (FIPS-197) encrypt/decrypt engine, one round per clock.

---
 rtl/aes128_pkg.sv | 134 +++++++++++++
 rtl/aes128_crypto_core_if.sv | 12 +
 rtl/aes128_key_expand.sv | 22 ++
 rtl/aes128_crypto_core.sv | 122 ++++++++++++
 tb/tb_aes128_crypto_core.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/aes128_pkg.sv
// Shared types, tables and GF(2^8) helpers for the iterative AES-128 engine.
// Byte k of a 128-bit word sits at bits [127-8k -: 8]; column c holds bytes 4c..4c+3.
package aes128_pkg;

  typedef enum logic [1:0] {StIdle, StKeyExp, StInit, StRound} aes_state_e;

  localparam logic [3:0] LastKexp  = 4'd9;
  localparam logic [3:0] LastRound = 4'd10;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd0:    r = 8'h01;
      4'd1:    r = 8'h02;
      4'd2:    r = 8'h04;
      4'd3:    r = 8'h08;
      4'd4:    r = 8'h10;
      4'd5:    r = 8'h20;
      4'd6:    r = 8'h40;
      4'd7:    r = 8'h80;
      4'd8:    r = 8'h1b;
      4'd9:    r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant as a sum of a, 2a, 4a, 8a.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] m);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (m[0] ? a : 8'h00) ^ (m[1] ? x2 : 8'h00) ^ (m[2] ? x4 : 8'h00) ^ (m[3] ? x8 : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul(a0, 4'd2) ^ gmul(a1, 4'd3) ^ a2 ^ a3,
            a0 ^ gmul(a1, 4'd2) ^ gmul(a2, 4'd3) ^ a3,
            a0 ^ a1 ^ gmul(a2, 4'd2) ^ gmul(a3, 4'd3),
            gmul(a0, 4'd3) ^ a1 ^ a2 ^ gmul(a3, 4'd2)};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul(a0, 4'd14) ^ gmul(a1, 4'd11) ^ gmul(a2, 4'd13) ^ gmul(a3, 4'd9),
            gmul(a0, 4'd9) ^ gmul(a1, 4'd14) ^ gmul(a2, 4'd11) ^ gmul(a3, 4'd13),
            gmul(a0, 4'd13) ^ gmul(a1, 4'd9) ^ gmul(a2, 4'd14) ^ gmul(a3, 4'd11),
            gmul(a0, 4'd11) ^ gmul(a1, 4'd13) ^ gmul(a2, 4'd9) ^ gmul(a3, 4'd14)};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = sbox(s[127-8*k -: 8]);
    return r;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = inv_sbox(s[127-8*k -: 8]);
    return r;
  endfunction

  // Row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) begin
      for (int w = 0; w < 4; w++) begin
        r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c+w)%4)+w) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) begin
      for (int w = 0; w < 4; w++) begin
        r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c+4-w)%4)+w) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) r[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
    return r;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) r[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    return r;
  endfunction

endpackage

// File: rtl/aes128_crypto_core_if.sv
// Request/response bundle between a host and the AES-128 coprocessor.
interface aes128_crypto_core_if;
  logic         encdec;
  logic         start;
  logic [127:0] key;
  logic [127:0] textin;
  logic         done;
  logic [127:0] textout;

  modport master (output encdec, start, key, textin, input done, textout);
  modport slave  (input encdec, start, key, textin, output done, textout);
endinterface

// File: rtl/aes128_key_expand.sv
// One step of the AES-128 key schedule: rk[i] -> rk[i+1] with Rcon[i].
module aes128_key_expand
  import aes128_pkg::*;
(
  input  logic [127:0] rk_i,
  input  logic [7:0]   rcon_i,
  output logic [127:0] rk_o
);

  logic [31:0] w0, w1, w2, w3, rot, temp, n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = rk_i;
  assign rot  = {w3[23:0], w3[31:24]};
  assign temp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^
                {rcon_i, 24'h000000};
  assign n0   = w0 ^ temp;
  assign n1   = w1 ^ n0;
  assign n2   = w2 ^ n1;
  assign n3   = w3 ^ n2;
  assign rk_o = {n0, n1, n2, n3};

endmodule

// File: rtl/aes128_crypto_core.sv
// Iterative AES-128 encrypt/decrypt core, one round per clock, key schedule expanded in-core.
// Optional AES128_KEY_CACHE_EN: skip key expansion when the key matches the last expanded one.
module aes128_crypto_core
  import aes128_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  aes128_crypto_core_if.slave bus
);

  aes_state_e   state_q, state_d;
  logic [3:0]   cnt_q, dec_idx;
  logic [127:0] rk_q [11];
  logic [127:0] text_q, blk_q, textout_q, rk_next, round_out;
  logic         decrypt_q, done_q, key_hit;
  logic         accept, kexp_en, init_en, round_en, last_round;

  aes128_key_expand u_key_expand (
    .rk_i   (rk_q[cnt_q]),
    .rcon_i (rcon(cnt_q)),
    .rk_o   (rk_next)
  );

`ifdef AES128_KEY_CACHE_EN
  // rk_q[0] doubles as the copy of the last expanded key.
  logic key_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      key_valid_q <= 1'b0;
    end else if (kexp_en) begin
      key_valid_q <= (cnt_q == LastKexp);
    end
  end

  assign key_hit = key_valid_q && (bus.key == rk_q[0]);
`else
  assign key_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (bus.start) state_d = key_hit ? StInit : StKeyExp;
      StKeyExp: if (cnt_q == LastKexp) state_d = StInit;
      StInit:   state_d = StRound;
      StRound:  if (cnt_q == LastRound) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    accept     = 1'b0;
    kexp_en    = 1'b0;
    init_en    = 1'b0;
    round_en   = 1'b0;
    last_round = 1'b0;
    unique case (state_q)
      StIdle:   accept = bus.start;
      StKeyExp: kexp_en = 1'b1;
      StInit:   init_en = 1'b1;
      StRound: begin
        round_en   = 1'b1;
        last_round = (cnt_q == LastRound);
      end
      default: ;
    endcase
  end

  always_comb begin
    logic [127:0] sr, enc, ak, dec;
    dec_idx   = LastRound - cnt_q;
    sr        = shift_rows(sub_bytes(blk_q));
    enc       = (last_round ? sr : mix_columns(sr)) ^ rk_q[cnt_q];
    ak        = inv_sub_bytes(inv_shift_rows(blk_q)) ^ rk_q[dec_idx];
    dec       = last_round ? ak : inv_mix_columns(ak);
    round_out = decrypt_q ? dec : enc;
  end

  // Round keys need no reset: they are always rebuilt or validated before use.
  always_ff @(posedge clk) begin
    if (accept)  rk_q[0] <= bus.key;
    if (kexp_en) rk_q[cnt_q + 4'd1] <= rk_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      text_q    <= '0;
      blk_q     <= '0;
      decrypt_q <= 1'b0;
      done_q    <= 1'b0;
      textout_q <= '0;
    end else begin
      done_q <= last_round;
      if (accept) begin
        text_q    <= bus.textin;
        decrypt_q <= bus.encdec;
        cnt_q     <= '0;
      end
      if (kexp_en) cnt_q <= cnt_q + 4'd1;
      if (init_en) begin
        blk_q <= text_q ^ (decrypt_q ? rk_q[10] : rk_q[0]);
        cnt_q <= 4'd1;
      end
      if (round_en) begin
        blk_q <= round_out;
        if (last_round) textout_q <= round_out;
        else            cnt_q     <= cnt_q + 4'd1;
      end
    end
  end

  assign bus.done    = done_q;
  assign bus.textout = textout_q;

endmodule

// File: tb/tb_aes128_crypto_core.sv
// Directed-vector bench for aes128_crypto_core (FIPS-197 / SP800-38A vectors, latency, reset abort).
module tb_aes128_crypto_core;

  localparam logic [127:0] KeyA = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PtA  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CtA  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KeyB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PtB  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CtB  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] CtZ  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam int LatFull = 21;
`ifdef AES128_KEY_CACHE_EN
  localparam int LatHit = 11;
`else
  localparam int LatHit = 21;
`endif

  logic clk = 1'b0;
  logic rst;
  int   tests_run = 0;
  int   tests_failed = 0;

  aes128_crypto_core_if bus ();

  aes128_crypto_core dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Issue one operation; lat = edges from the START edge to the DONE edge, 0 on timeout.
  task automatic run_op(input logic [127:0] k, input logic [127:0] t, input logic ed,
                        output int lat, output logic [127:0] res);
    int  n;
    bit  seen;
    @(negedge clk);
    bus.key = k; bus.textin = t; bus.encdec = ed; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.key = ~k; bus.textin = ~t; bus.encdec = ~ed;
    lat = 0; res = '0; n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        seen = 1'b1; lat = n; res = bus.textout;
      end else begin
        n++;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; bus.start = 1'b0; bus.encdec = 1'b0; bus.key = '0; bus.textin = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (bus.done !== 1'b0) begin
      tests_failed++; $display("FAIL reset_done: got %b expected 0", bus.done);
    end
    tests_run++;
    if (bus.textout !== 128'h0) begin
      tests_failed++; $display("FAIL reset_textout: got %h expected 0", bus.textout);
    end
    rst = 1'b0;
  endtask

  task automatic test_pair(input string name, input logic [127:0] k, input logic [127:0] pt,
                           input logic [127:0] ct, input int lat_enc, input int lat_dec);
    int lat; logic [127:0] res;
    run_op(k, pt, 1'b0, lat, res);
    tests_run++;
    if (lat !== lat_enc) begin
      tests_failed++; $display("FAIL %s_enc_latency: got %0d expected %0d", name, lat, lat_enc);
    end
    tests_run++;
    if (res !== ct) begin
      tests_failed++; $display("FAIL %s_enc_result: got %h expected %h", name, res, ct);
    end
    run_op(k, ct, 1'b1, lat, res);
    tests_run++;
    if (lat !== lat_dec) begin
      tests_failed++; $display("FAIL %s_dec_latency: got %0d expected %0d", name, lat, lat_dec);
    end
    tests_run++;
    if (res !== pt) begin
      tests_failed++; $display("FAIL %s_dec_result: got %h expected %h", name, res, pt);
    end
  endtask

  task automatic test_zero_key_busy;
    int n, extra;
    bit seen, held_ok;
    @(negedge clk);
    bus.key = '0; bus.textin = '0; bus.encdec = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.key = KeyB; bus.textin = CtB; bus.encdec = 1'b1;
    n = 0; seen = 1'b0; held_ok = 1'b1;
    while (!seen && n < 40) begin
      @(posedge clk);
      n++;
      #1;
      bus.start = (n == 4 || n == 14);
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1'b1;
      else if (bus.textout !== PtB) held_ok = 1'b0;
    end
    bus.start = 1'b0;
    tests_run++;
    if (!seen || n != LatFull) begin
      tests_failed++; $display("FAIL zero_latency: got %0d expected %0d", seen ? n : 0, LatFull);
    end
    tests_run++;
    if (bus.textout !== CtZ) begin
      tests_failed++; $display("FAIL zero_result: got %h expected %h", bus.textout, CtZ);
    end
    tests_run++;
    if (!held_ok) begin
      tests_failed++; $display("FAIL busy_textout_held: got changed expected %h", PtB);
    end
    @(negedge clk);
    tests_run++;
    if (bus.done !== 1'b0) begin
      tests_failed++; $display("FAIL done_width: got %b expected 0 one cycle later", bus.done);
    end
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done === 1'b1) extra++;
    end
    tests_run++;
    if (extra != 0) begin
      tests_failed++; $display("FAIL busy_start_ignored: got %0d extra pulses expected 0", extra);
    end
    tests_run++;
    if (bus.textout !== CtZ) begin
      tests_failed++; $display("FAIL zero_result_held: got %h expected %h", bus.textout, CtZ);
    end
  endtask

  task automatic test_reset_abort;
    int seen_cnt, lat;
    logic [127:0] res;
    @(negedge clk);
    bus.key = KeyA; bus.textin = PtA; bus.encdec = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen_cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen_cnt++;
    end
    tests_run++;
    if (seen_cnt != 0) begin
      tests_failed++; $display("FAIL abort_no_done: got %0d pulses expected 0", seen_cnt);
    end
    tests_run++;
    if (bus.textout !== 128'h0) begin
      tests_failed++; $display("FAIL abort_textout: got %h expected 0", bus.textout);
    end
    run_op(KeyA, PtA, 1'b0, lat, res);
    tests_run++;
    if (lat != LatFull) begin
      tests_failed++; $display("FAIL after_abort_latency: got %0d expected %0d", lat, LatFull);
    end
    tests_run++;
    if (res !== CtA) begin
      tests_failed++; $display("FAIL after_abort_result: got %h expected %h", res, CtA);
    end
  endtask

  task automatic test_key_cache;
    int lat;
    logic [127:0] res;
    test_pair("cache_same_key", KeyA, PtA, CtA, LatHit, LatHit);
    run_op(KeyB, PtB, 1'b0, lat, res);
    tests_run++;
    if (lat != LatFull) begin
      tests_failed++; $display("FAIL cache_new_key_latency: got %0d expected %0d", lat, LatFull);
    end
    tests_run++;
    if (res !== CtB) begin
      tests_failed++; $display("FAIL cache_new_key_result: got %h expected %h", res, CtB);
    end
    run_op(KeyB, CtB, 1'b1, lat, res);
    tests_run++;
    if (lat != LatHit) begin
      tests_failed++; $display("FAIL cache_reuse_latency: got %0d expected %0d", lat, LatHit);
    end
    tests_run++;
    if (res !== PtB) begin
      tests_failed++; $display("FAIL cache_reuse_result: got %h expected %h", res, PtB);
    end
  endtask

  initial begin
    test_reset();
    test_pair("fips197", KeyA, PtA, CtA, LatFull, LatHit);
    test_pair("sp800", KeyB, PtB, CtB, LatFull, LatHit);
    test_zero_key_busy();
    test_reset_abort();
    test_key_cache();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
